add_reservation_station: RTL and testbench

// - Receiving end of the instruction-fetch stream for the ADD/SUB unit (Tomasulo issue stage).
// - Captures ADD/SUB words from the fetch queue into NUM_RS entries and renames operands via register status.
// - Snoops the CDB for pending operands and dispatches ready entries to the adder.
// - Reports occupancy on add_full_control; fetch stalls while it reads 3.

---
 rtl/add_reservation_station_pkg.sv | 29 ++
 rtl/add_reservation_station_rs_entry.sv | 109 ++++++++++
 rtl/add_reservation_station.sv | 106 ++++++++++
 tb/tb_add_reservation_station.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/add_reservation_station_pkg.sv
// Shared definitions for the ADD/SUB reservation station:
// opcodes, fetch-word field slices and the "value ready" tag.
package add_reservation_station_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam int TAG_NONE = 0;

  function automatic logic [2:0] f_op(input logic [11:0] w);
    return w[2:0];
  endfunction

  function automatic logic [2:0] f_rs(input logic [11:0] w);
    return w[5:3];
  endfunction

  function automatic logic [2:0] f_rd(input logic [11:0] w);
    return w[8:6];
  endfunction

  function automatic logic [2:0] f_rt(input logic [11:0] w);
    return w[11:9];
  endfunction

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/add_reservation_station_rs_entry.sv
// One reservation-station slot: holds op and operands,
// snoops the CDB for pending tags and flags itself ready.
module add_reservation_station_rs_entry
  import add_reservation_station_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              alloc_op,
  input  logic [DATA_W-1:0] alloc_vj,
  input  logic [TAG_W-1:0]  alloc_qj,
  input  logic [DATA_W-1:0] alloc_vk,
  input  logic [TAG_W-1:0]  alloc_qk,
  input  logic              dispatch,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              busy,
  output logic              ready,
  output logic              op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  localparam logic [TAG_W-1:0] TNONE = TAG_W'(TAG_NONE);

  logic              busy_q, busy_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    if (alloc) begin
      busy_d = 1'b1;
      op_d   = alloc_op;
      // A broadcast on the issue edge is forwarded, else the tag would be missed
      if (alloc_qj == TNONE) begin
        vj_d = alloc_vj;
        qj_d = TNONE;
      end else if (cdb_valid && cdb_tag == alloc_qj) begin
        vj_d = cdb_data;
        qj_d = TNONE;
      end else begin
        vj_d = '0;
        qj_d = alloc_qj;
      end
      if (alloc_qk == TNONE) begin
        vk_d = alloc_vk;
        qk_d = TNONE;
      end else if (cdb_valid && cdb_tag == alloc_qk) begin
        vk_d = cdb_data;
        qk_d = TNONE;
      end else begin
        vk_d = '0;
        qk_d = alloc_qk;
      end
    end else if (dispatch) begin
      busy_d = 1'b0;
      op_d   = 1'b0;
      vj_d   = '0;
      vk_d   = '0;
      qj_d   = TNONE;
      qk_d   = TNONE;
    end else if (busy_q && cdb_valid) begin
      if (qj_q != TNONE && cdb_tag == qj_q) begin
        vj_d = cdb_data;
        qj_d = TNONE;
      end
      if (qk_q != TNONE && cdb_tag == qk_q) begin
        vk_d = cdb_data;
        qk_d = TNONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      op_q   <= 1'b0;
      vj_q   <= '0;
      vk_q   <= '0;
      qj_q   <= TNONE;
      qk_q   <= TNONE;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      qj_q   <= qj_d;
      qk_q   <= qk_d;
    end
  end

  assign busy  = busy_q;
  assign ready = busy_q && qj_q == TNONE && qk_q == TNONE;
  assign op    = op_q;
  assign vj    = vj_q;
  assign vk    = vk_q;

endmodule

// File: rtl/add_reservation_station.sv
// ADD/SUB reservation station: allocates fetch words into slots,
// renames via register status and dispatches ready slots to the adder.
module add_reservation_station
  import add_reservation_station_pkg::*;
#(
  parameter int NUM_RS   = 3,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       inst,
  output logic [2:0]        add_full_control,
  output logic [2:0]        rs_addr,
  output logic [2:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [TAG_W-1:0]  rs_qi,
  input  logic [TAG_W-1:0]  rt_qi,
  output logic              rat_wr_en,
  output logic [2:0]        rat_wr_addr,
  output logic [TAG_W-1:0]  rat_wr_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic              ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [TAG_W-1:0]  ex_tag
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0] busy, ready, avail, ent_op;
  logic [DATA_W-1:0] ent_vj [NUM_RS];
  logic [DATA_W-1:0] ent_vk [NUM_RS];
  logic [IDX_W-1:0]  rdy_sel, free_sel;
  logic [2:0]        count_q, count_d;
  logic              accept, dispatch;

  always_comb begin
    accept   = !reset && is_alu(f_op(inst))
               && count_q != 3'(NUM_RS);
    ex_valid = 1'b0;
    rdy_sel  = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (ready[i]) begin
        ex_valid = 1'b1;
        rdy_sel  = IDX_W'(i);
      end
    end
    dispatch = ex_valid && ex_ready;
    // A slot leaving this edge may be refilled on the same edge
    free_sel = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      avail[i] = !busy[i] || (dispatch && rdy_sel == IDX_W'(i));
      if (avail[i]) free_sel = IDX_W'(i);
    end
    count_d = count_q + 3'(accept) - 3'(dispatch);
  end

  for (genvar i = 0; i < NUM_RS; i++) begin : g_ent
    add_reservation_station_rs_entry #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) u_ent (
      .clk      (clk),
      .reset    (reset),
      .alloc    (accept && free_sel == IDX_W'(i)),
      .alloc_op (f_op(inst) == OP_SUB),
      .alloc_vj (rs_data),
      .alloc_qj (rs_qi),
      .alloc_vk (rt_data),
      .alloc_qk (rt_qi),
      .dispatch (dispatch && rdy_sel == IDX_W'(i)),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_data (cdb_data),
      .busy     (busy[i]),
      .ready    (ready[i]),
      .op       (ent_op[i]),
      .vj       (ent_vj[i]),
      .vk       (ent_vk[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign add_full_control = count_q;
  assign rs_addr     = f_rs(inst);
  assign rt_addr     = f_rt(inst);
  assign rat_wr_en   = accept;
  assign rat_wr_addr = f_rd(inst);
  assign rat_wr_tag  = TAG_W'(TAG_BASE) + TAG_W'(free_sel);
  assign ex_op       = ent_op[rdy_sel];
  assign ex_a        = ent_vj[rdy_sel];
  assign ex_b        = ent_vk[rdy_sel];
  assign ex_tag      = TAG_W'(TAG_BASE) + TAG_W'(rdy_sel);

endmodule

// File: tb/tb_add_reservation_station.sv
// Directed vector bench for the ADD/SUB reservation station.
module tb_add_reservation_station;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] inst;
  logic [2:0]  add_full_control, rs_addr, rt_addr;
  logic [15:0] rs_data, rt_data;
  logic [2:0]  rs_qi, rt_qi;
  logic        rat_wr_en;
  logic [2:0]  rat_wr_addr, rat_wr_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        ex_valid, ex_ready, ex_op;
  logic [15:0] ex_a, ex_b;
  logic [2:0]  ex_tag;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  add_reservation_station dut (
    .clk(clk), .reset(reset), .inst(inst),
    .add_full_control(add_full_control),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_qi(rs_qi), .rt_qi(rt_qi),
    .rat_wr_en(rat_wr_en), .rat_wr_addr(rat_wr_addr),
    .rat_wr_tag(rat_wr_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_tag(ex_tag)
  );

  typedef struct {
    logic [11:0] inst;
    logic [15:0] rsd;
    logic [2:0]  rsq;
    logic [15:0] rtd;
    logic [2:0]  rtq;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic        rdy;
    logic        e_wr;
    logic [2:0]  e_wtag;
    logic [2:0]  e_cnt;
    logic        e_exv;
    logic        e_op;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [2:0]  e_xtag;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int row,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
  endtask

  function automatic vec_t v(
    input logic [11:0] i, input logic [15:0] rsd, input logic [2:0] rsq,
    input logic [15:0] rtd, input logic [2:0] rtq,
    input logic cv, input logic [2:0] ct, input logic [15:0] cd,
    input logic rdy, input logic wr, input logic [2:0] wtag,
    input logic [2:0] cnt, input logic exv, input logic op,
    input logic [15:0] a, input logic [15:0] b, input logic [2:0] xt);
    vec_t r;
    r.inst = i; r.rsd = rsd; r.rsq = rsq; r.rtd = rtd; r.rtq = rtq;
    r.cv = cv; r.ct = ct; r.cd = cd; r.rdy = rdy;
    r.e_wr = wr; r.e_wtag = wtag; r.e_cnt = cnt; r.e_exv = exv;
    r.e_op = op; r.e_a = a; r.e_b = b; r.e_xtag = xt;
    return r;
  endfunction

  localparam logic [11:0] NOP  = 12'b000_000_000_111;
  localparam logic [11:0] A1   = 12'b001_010_000_000;
  localparam logic [11:0] S1   = 12'b011_100_101_001;
  localparam logic [11:0] A2   = 12'b010_011_001_000;
  localparam logic [11:0] AF   = 12'b001_110_010_000;

  initial begin
    reset = 1'b1; inst = NOP; rs_data = '0; rt_data = '0;
    rs_qi = '0; rt_qi = '0; cdb_valid = 1'b0; cdb_tag = '0;
    cdb_data = '0; ex_ready = 1'b0;

    //       inst rsd  rsq rtd  rtq cv ct cd     rdy wr wt cnt exv op a   b   xt
    tbl.push_back(v(A1,  1,  0, 1,  0, 0, 0, 0,     0, 1, 1, 0, 0, 0, 0,  0,  0));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 1, 1, 0, 1,  1,  1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     1, 0, 0, 1, 1, 0, 1,  1,  1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,  0,  0));
    tbl.push_back(v(S1,  0,  4, 5,  0, 0, 0, 0,     0, 1, 1, 0, 0, 0, 0,  0,  0));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 1, 4, 2,     0, 0, 0, 1, 0, 0, 0,  0,  0));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 1, 1, 1, 2,  5,  1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     1, 0, 0, 1, 1, 1, 2,  5,  1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,  0,  0));
    tbl.push_back(v(A2,  4,  0, 0,  2, 1, 2, 7,     0, 1, 1, 0, 0, 0, 0,  0,  0));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 1, 1, 0, 4,  7,  1));
    tbl.push_back(v(AF,  0,  5, 3,  0, 0, 0, 0,     0, 1, 2, 1, 1, 0, 4,  7,  1));
    tbl.push_back(v(AF,  0,  5, 3,  0, 0, 0, 0,     0, 1, 3, 2, 1, 0, 4,  7,  1));
    tbl.push_back(v(AF,  0,  5, 3,  0, 0, 0, 0,     0, 0, 0, 3, 1, 0, 4,  7,  1));
    tbl.push_back(v(AF,  0,  5, 3,  0, 0, 0, 0,     0, 0, 0, 3, 1, 0, 4,  7,  1));
    tbl.push_back(v(AF,  0,  5, 3,  0, 0, 0, 0,     1, 0, 0, 3, 1, 0, 4,  7,  1));
    tbl.push_back(v(AF,  0,  5, 3,  0, 0, 0, 0,     0, 1, 1, 2, 0, 0, 0,  0,  0));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 1, 5, 9,     0, 0, 0, 3, 0, 0, 0,  0,  0));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 3, 1, 0, 9,  3,  1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     1, 0, 0, 3, 1, 0, 9,  3,  1));
    tbl.push_back(v(AF,  6,  0, 8,  0, 0, 0, 0,     1, 1, 1, 2, 1, 0, 9,  3,  2));
    tbl.push_back(v(AF, 10,  0, 11, 0, 0, 0, 0,     1, 1, 1, 2, 1, 0, 6,  8,  1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 1, 6, 16'hffff, 0, 0, 0, 2, 1, 0, 10, 11, 1));
    tbl.push_back(v(NOP, 0,  0, 0,  0, 0, 0, 0,     0, 0, 0, 2, 1, 0, 10, 11, 1));

    // reset held two cycles with an ADD presented
    @(negedge clk); inst = A1;
    #1 chk("rst_wr_en", -1, 16'(rat_wr_en), 16'd0);
    @(negedge clk);
    @(negedge clk); inst = NOP;
    #1;
    chk("rst_count", -1, 16'(add_full_control), 16'd0);
    chk("rst_exv", -1, 16'(ex_valid), 16'd0);
    chk("rst_wr_en2", -1, 16'(rat_wr_en), 16'd0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      inst = tbl[k].inst; rs_data = tbl[k].rsd; rs_qi = tbl[k].rsq;
      rt_data = tbl[k].rtd; rt_qi = tbl[k].rtq;
      cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; cdb_data = tbl[k].cd;
      ex_ready = tbl[k].rdy;
      #1;
      chk("rs_addr", k, 16'(rs_addr), 16'(tbl[k].inst[5:3]));
      chk("rt_addr", k, 16'(rt_addr), 16'(tbl[k].inst[11:9]));
      chk("count", k, 16'(add_full_control), 16'(tbl[k].e_cnt));
      chk("rat_wr_en", k, 16'(rat_wr_en), 16'(tbl[k].e_wr));
      if (tbl[k].e_wr) begin
        chk("rat_wr_tag", k, 16'(rat_wr_tag), 16'(tbl[k].e_wtag));
        chk("rat_wr_addr", k, 16'(rat_wr_addr), 16'(tbl[k].inst[8:6]));
      end
      chk("ex_valid", k, 16'(ex_valid), 16'(tbl[k].e_exv));
      if (tbl[k].e_exv) begin
        chk("ex_op", k, 16'(ex_op), 16'(tbl[k].e_op));
        chk("ex_a", k, ex_a, tbl[k].e_a);
        chk("ex_b", k, ex_b, tbl[k].e_b);
        chk("ex_tag", k, 16'(ex_tag), 16'(tbl[k].e_xtag));
      end
    end

    // reset in the middle of operation discards both live entries
    @(negedge clk);
    inst = AF; rs_qi = 3'd0; rs_data = 16'd1; ex_ready = 1'b0;
    cdb_valid = 1'b0; reset = 1'b1;
    #1 chk("midrst_wr_en", -2, 16'(rat_wr_en), 16'd0);
    @(negedge clk); inst = NOP;
    #1;
    chk("midrst_count", -2, 16'(add_full_control), 16'd0);
    chk("midrst_exv", -2, 16'(ex_valid), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_count", -2, 16'(add_full_control), 16'd0);
    chk("post_rst_exv", -2, 16'(ex_valid), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
